// File: rtl/snowflake_sys_pkg.sv
// Shared definitions for the snowflake system controller.
//   - Register word indices (sys_addr[7:2]) for the 0x1000-0x10FF window
//   - UART transmitter state encoding
//   - UART_STATUS bit positions
package snowflake_sys_pkg;

    localparam logic [5:0] SYS_MTIME_LO    = 6'h00;
    localparam logic [5:0] SYS_MTIME_HI    = 6'h01;
    localparam logic [5:0] SYS_MTIMECMP_LO = 6'h02;
    localparam logic [5:0] SYS_MTIMECMP_HI = 6'h03;
    localparam logic [5:0] SYS_UART_TX     = 6'h04;
    localparam logic [5:0] SYS_UART_STATUS = 6'h05;
    localparam logic [5:0] SYS_LED         = 6'h06;
    localparam logic [5:0] SYS_MSIP        = 6'h07;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_FULL_BIT = 1;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/snowflake_uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register.
//   clk, rst   : clock, synchronous active-high reset
//   wr         : write strobe into the holding register
//   wr_data    : byte to transmit
//   busy       : shifter active (state != IDLE)
//   full       : holding register occupied
//   tx         : serial line, idle high
//
// state      | meaning
// UART_IDLE  | line high; loads holding byte when full
// UART_START | start bit (0) for UART_DIV cycles
// UART_DATA  | 8 data bits LSB first, UART_DIV cycles each
// UART_STOP  | stop bit (1) for UART_DIV cycles
module snowflake_uart_tx
    import snowflake_sys_pkg::*;
#(
    parameter int UART_DIV = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       full,
    output logic       tx
);

    localparam int BW = $clog2(UART_DIV);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(UART_DIV - 1);

    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          full_q, full_d;
    logic          tx_q, tx_d;
    logic          load;
    logic          baud_tc;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        full_d  = full_q;
        load    = (state_q == UART_IDLE) && full_q;
        baud_tc = (baud_q == '0);

        case (state_q)
            UART_IDLE: begin
                if (full_q) begin
                    state_d = UART_START;
                    baud_d  = BAUD_RELOAD;
                    shift_d = hold_q;
                end
            end
            UART_START: begin
                if (baud_tc) begin
                    state_d = UART_DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd7;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            UART_DATA: begin
                if (baud_tc) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd0) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_d   = bit_q - 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            UART_STOP: begin
                if (baud_tc) begin
                    state_d = UART_IDLE;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase

        // The slot frees on the load edge, so a write on that same edge is kept.
        if (load) begin
            full_d = 1'b0;
        end
        if (wr && (!full_q || load)) begin
            full_d = 1'b1;
            hold_d = wr_data;
        end

        // tx is registered from the next state so it lines up with state_q.
        case (state_d)
            UART_START: tx_d = 1'b0;
            UART_DATA:  tx_d = shift_d[0];
            default:    tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            tx_q    <= tx_d;
        end
    end

    assign busy = (state_q != UART_IDLE);
    assign full = full_q;
    assign tx   = tx_q;

endmodule

// File: rtl/snowflake_system_ctrl.sv
// Snowflake system controller: responder for the 0x1000-0x10FF window.
// Holds the 64-bit mtime/mtimecmp timer, a UART transmitter and an LED register.
//   clk, rst          : clock, synchronous active-high reset
//   sys_addr          : byte address, only [7:2] decoded
//   sys_wr_data       : full-word write data
//   sys_en, sys_wr_en : access strobe and direction
//   sys_rd_data       : read data, registered, valid the cycle after the request
//   timer_irq         : registered mtime >= mtimecmp
//   soft_irq          : MSIP bit (tied 0 unless SNOWFLAKE_SYS_MSIP_EN is defined)
//   uart_tx           : serial output
//   led               : LED register
// Optional build macro: SNOWFLAKE_SYS_MSIP_EN enables the MSIP register at 0x1C.
module snowflake_system_ctrl
    import snowflake_sys_pkg::*;
#(
    parameter int TIME_PRESCALE = 25,
    parameter int UART_DIV      = 217,
    parameter int LED_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      sys_addr,
    output logic [31:0]      sys_rd_data,
    input  logic [31:0]      sys_wr_data,
    input  logic             sys_en,
    input  logic             sys_wr_en,
    output logic             timer_irq,
    output logic             soft_irq,
    output logic             uart_tx,
    output logic [LED_W-1:0] led
);

    localparam int PW = (TIME_PRESCALE > 1) ? $clog2(TIME_PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIME_PRESCALE - 1);

    logic [5:0]       word;
    logic             wr_req, rd_req;
    logic             tick;
    logic             uart_wr, uart_busy, uart_full;
    logic [31:0]      rd_val;

    logic [PW-1:0]    presc_q, presc_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             timer_irq_q, timer_irq_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      rd_data_q, rd_data_d;

    // Upper address bits are decoded by the bus; byte-lane bits are meaningless here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sys_addr[31:8], sys_addr[1:0]};

    assign word    = sys_addr[7:2];
    assign wr_req  = sys_en && sys_wr_en;
    assign rd_req  = sys_en && !sys_wr_en;
    assign tick    = (presc_q == PRESC_LAST);
    assign uart_wr = wr_req && (word == SYS_UART_TX);

`ifdef SNOWFLAKE_SYS_MSIP_EN
    logic msip_q, msip_d;
    always_comb begin
        msip_d = msip_q;
        if (wr_req && word == SYS_MSIP) begin
            msip_d = sys_wr_data[0];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) msip_q <= 1'b0;
        else     msip_q <= msip_d;
    end
    assign soft_irq = msip_q;
`else
    assign soft_irq = 1'b0;
`endif

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);

        // A software write to either half wins over a tick in the same cycle.
        mtime_d = mtime_q;
        if (wr_req && word == SYS_MTIME_LO) begin
            mtime_d[31:0] = sys_wr_data;
        end else if (wr_req && word == SYS_MTIME_HI) begin
            mtime_d[63:32] = sys_wr_data;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        mtimecmp_d = mtimecmp_q;
        if (wr_req && word == SYS_MTIMECMP_LO) mtimecmp_d[31:0]  = sys_wr_data;
        if (wr_req && word == SYS_MTIMECMP_HI) mtimecmp_d[63:32] = sys_wr_data;

        timer_irq_d = (mtime_q >= mtimecmp_q);

        led_d = led_q;
        if (wr_req && word == SYS_LED) led_d = sys_wr_data[LED_W-1:0];

        rd_val = '0;
        case (word)
            SYS_MTIME_LO:    rd_val = mtime_q[31:0];
            SYS_MTIME_HI:    rd_val = mtime_q[63:32];
            SYS_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
            SYS_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
            SYS_UART_STATUS: begin
                rd_val[STAT_BUSY_BIT] = uart_busy;
                rd_val[STAT_FULL_BIT] = uart_full;
            end
            SYS_LED:         rd_val = 32'(led_q);
`ifdef SNOWFLAKE_SYS_MSIP_EN
            SYS_MSIP:        rd_val = {31'b0, msip_q};
`endif
            default:         rd_val = '0;
        endcase

        rd_data_d = rd_req ? rd_val : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            timer_irq_q <= 1'b0;
            led_q       <= '0;
            rd_data_q   <= '0;
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            timer_irq_q <= timer_irq_d;
            led_q       <= led_d;
            rd_data_q   <= rd_data_d;
        end
    end

    snowflake_uart_tx #(
        .UART_DIV (UART_DIV)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .wr      (uart_wr),
        .wr_data (sys_wr_data[7:0]),
        .busy    (uart_busy),
        .full    (uart_full),
        .tx      (uart_tx)
    );

    assign sys_rd_data = rd_data_q;
    assign timer_irq   = timer_irq_q;
    assign led         = led_q;

endmodule

// File: tb/tb_snowflake_system_ctrl.sv
module tb_snowflake_system_ctrl;

    localparam int P   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sys_addr = '0;
    logic [31:0] sys_rd_data;
    logic [31:0] sys_wr_data = '0;
    logic        sys_en = 1'b0;
    logic        sys_wr_en = 1'b0;
    logic        timer_irq, soft_irq, uart_tx;
    logic [7:0]  led;

    snowflake_system_ctrl #(
        .TIME_PRESCALE (P),
        .UART_DIV      (DIV),
        .LED_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sys_addr    (sys_addr),
        .sys_rd_data (sys_rd_data),
        .sys_wr_data (sys_wr_data),
        .sys_en      (sys_en),
        .sys_wr_en   (sys_wr_en),
        .timer_irq   (timer_irq),
        .soft_irq    (soft_irq),
        .uart_tx     (uart_tx),
        .led         (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        string       tag;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] byte_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         frames_done = 0;
    bit         mon_armed = 1'b0;
    int         presc_m = 0;

    // Independent prescaler phase model, used only to place writes relative to ticks.
    always @(posedge clk) begin
        if (rst) presc_m <= 0;
        else     presc_m <= (presc_m == P - 1) ? 0 : presc_m + 1;
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Tasks are entered at a negedge and return at the following negedge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        sys_addr    = addr;
        sys_wr_data = data;
        sys_en      = 1'b1;
        sys_wr_en   = 1'b1;
        @(negedge clk);
        sys_en      = 1'b0;
        sys_wr_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        rd_exp_t e;
        e.data = exp;
        e.tag  = tag;
        rd_q.push_back(e);
        sys_addr  = addr;
        sys_en    = 1'b1;
        sys_wr_en = 1'b0;
        @(negedge clk);
        sys_en = 1'b0;
        e = rd_q.pop_front();
        check(sys_rd_data, e.data, e.tag);
    endtask

    task automatic align_presc(input int phase);
        for (int i = 0; i < 2 * P && presc_m != phase; i++) @(negedge clk);
    endtask

    // Write HI, then LO=all-ones on a non-tick edge; the first tick carries into HI.
    task automatic carry_test(input logic [31:0] hi_in, input logic [31:0] exp_hi, input string tag);
        bus_write(32'h1004, hi_in);
        align_presc(0);
        bus_write(32'h1000, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        bus_read(32'h1000, 32'h0, {tag, "_lo"});
        bus_read(32'h1004, exp_hi, {tag, "_hi"});
    endtask

    // UART line monitor: captures whole frames and compares them with queued bytes.
    initial begin : uart_mon
        logic [39:0] cap;
        logic [9:0]  fb;
        logic [7:0]  eb;
        bit          pending_start;
        pending_start = 1'b0;
        forever begin
            if (!pending_start) @(negedge clk);
            pending_start = 1'b0;
            if (mon_armed && !rst && uart_tx === 1'b0) begin
                cap    = '0;
                cap[0] = uart_tx;
                for (int k = 1; k < 40; k++) begin
                    @(negedge clk);
                    cap[k] = uart_tx;
                end
                check(32'(byte_q.size() != 0), 32'd1, "uart_frame_expected");
                eb = (byte_q.size() != 0) ? byte_q.pop_front() : 8'h00;
                fb = {1'b1, eb, 1'b0};
                for (int s = 0; s < 10; s++) begin
                    check({28'b0, cap[4*s +: 4]}, {28'b0, {4{fb[s]}}},
                          $sformatf("uart_f%0d_slot%0d", frames_done, s));
                end
                frames_done++;
                if (byte_q.size() != 0) begin
                    @(negedge clk);
                    check({31'b0, uart_tx}, 32'd1, "uart_gap_idle");
                    @(negedge clk);
                    check({31'b0, uart_tx}, 32'd0, "uart_gap_next_start");
                    pending_start = 1'b1;
                end
            end
        end
    end

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check({31'b0, uart_tx},   32'd1, "rst_uart_tx");
        check({31'b0, timer_irq}, 32'd0, "rst_timer_irq");
        check({31'b0, soft_irq},  32'd0, "rst_soft_irq");
        check({24'b0, led},       32'd0, "rst_led");
        check(sys_rd_data,        32'd0, "rst_rd_data");
        bus_read(32'h1000, 32'h0,         "rst_mtime_lo");
        bus_read(32'h1008, 32'hFFFF_FFFF, "rst_mtimecmp_lo_lat1");
        @(negedge clk);
        check(sys_rd_data, 32'hFFFF_FFFF, "rd_hold_idle");
        bus_read(32'h100C, 32'hFFFF_FFFF, "rst_mtimecmp_hi");
        bus_read(32'h1014, 32'h0,         "rst_uart_status");
        bus_read(32'h1018, 32'h0,         "rst_led_reg");

        // ---------------- LED / decode ----------------
        bus_read(32'h100C, 32'hFFFF_FFFF, "cmp_hi_again");
        bus_write(32'h1018, 32'h0000_00A5);
        check(sys_rd_data, 32'hFFFF_FFFF, "wr_keeps_rd_data");
        check({24'b0, led}, 32'h0000_00A5, "led_port");
        bus_read(32'h1018, 32'h0000_00A5, "led_read");
        bus_write(32'h1018, 32'hFFFF_FF3C);
        bus_read(32'h0000_F318, 32'h0000_003C, "led_alias_trunc");
        bus_write(32'h1020, 32'hDEAD_BEEF);
        bus_read(32'h1020, 32'h0, "unmapped_0x20");
        bus_read(32'h10FC, 32'h0, "unmapped_0xFC");
        check({24'b0, led}, 32'h0000_003C, "led_after_unmapped_wr");

        // ---------------- timer carry / wrap / tick collision ----------------
        carry_test(32'h0000_0000, 32'h0000_0001, "carry");
        carry_test(32'hFFFF_FFFF, 32'h0000_0000, "wrap64");
        align_presc(P - 1);
        bus_write(32'h1000, 32'h1234_0000);
        bus_read(32'h1000, 32'h1234_0000, "wr_beats_tick_lo");
        bus_read(32'h1004, 32'h0,         "wr_beats_tick_hi");

        // ---------------- timer interrupt ----------------
        bus_write(32'h1004, 32'h0);
        align_presc(0);
        bus_write(32'h1000, 32'h0);
        bus_write(32'h1008, 32'd10);
        bus_write(32'h100C, 32'h0);
        repeat (37) @(negedge clk);
        check({31'b0, timer_irq}, 32'd0, "irq_not_yet");
        @(negedge clk);
        check({31'b0, timer_irq}, 32'd1, "irq_rise");
        bus_read(32'h1000, 32'd10, "irq_mtime_lo");
        bus_write(32'h100C, 32'hFFFF_FFFF);
        check({31'b0, timer_irq}, 32'd1, "irq_lag");
        bus_write(32'h1008, 32'hFFFF_FFFF);
        check({31'b0, timer_irq}, 32'd0, "irq_drop");

        // ---------------- MSIP ----------------
        bus_write(32'h101C, 32'h1);
`ifdef SNOWFLAKE_SYS_MSIP_EN
        check({31'b0, soft_irq}, 32'd1, "msip_soft_irq");
        bus_read(32'h101C, 32'h1, "msip_read");
        bus_write(32'h101C, 32'h0);
        check({31'b0, soft_irq}, 32'd0, "msip_clear");
`else
        check({31'b0, soft_irq}, 32'd0, "msip_off_soft_irq");
        bus_read(32'h101C, 32'h0, "msip_off_read");
`endif

        // ---------------- UART frames and back-pressure ----------------
        mon_armed = 1'b1;
        byte_q.push_back(8'h55);
        bus_write(32'h1010, 32'h0000_0055);
        bus_read(32'h1014, 32'h2, "uart_status_held");
        bus_read(32'h1014, 32'h1, "uart_status_busy");
        byte_q.push_back(8'hA3);
        bus_write(32'h1010, 32'h0000_00A3);
        bus_read(32'h1014, 32'h3, "uart_status_busy_full");
        bus_write(32'h1010, 32'h0000_007E);
        bus_read(32'h1014, 32'h3, "uart_status_after_drop");
        bus_read(32'h1010, 32'h0, "uart_tx_reads_zero");
        for (int i = 0; i < 400 && frames_done < 2; i++) @(negedge clk);
        check(32'(frames_done), 32'd2, "uart_frames_done");
        repeat (60) @(negedge clk);
        check(32'(frames_done), 32'd2, "uart_no_extra_frame");
        bus_read(32'h1014, 32'h0, "uart_status_idle");

        // ---------------- reset mid-frame ----------------
        mon_armed = 1'b0;
        bus_write(32'h1010, 32'h0000_003C);
        bus_write(32'h1010, 32'h0000_00FF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({31'b0, uart_tx}, 32'd1, "midframe_rst_tx");
        bus_read(32'h1014, 32'h0,         "midframe_rst_status");
        bus_read(32'h1000, 32'h0,         "midframe_rst_mtime");
        bus_read(32'h1008, 32'hFFFF_FFFF, "midframe_rst_cmp");
        begin
            logic low_seen;
            low_seen = 1'b0;
            repeat (50) begin
                @(negedge clk);
                if (uart_tx !== 1'b1) low_seen = 1'b1;
            end
            check({31'b0, low_seen}, 32'd0, "midframe_rst_line_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snowflake_system_ctrl.md
Name: snowflake_system_ctrl

Overview:
- Responder on the snowflake system interface: the target behind the bus's sys_* port, window 0x1000-0x10FF, 64 words.
- Provides a RISC-V style 64-bit mtime/mtimecmp timer with a timer interrupt, an 8N1 UART transmitter with a one-byte holding register, and an LED output register.
- The bus registers sys_en into its data ack and samples sys_rd_data in that ack cycle, so read data must be registered with exactly 1-cycle latency.

Parameters:
TIME_PRESCALE, 25, clk cycles per mtime increment (>=1)
UART_DIV, 217, clk cycles per UART bit (>=2)
LED_W, 8, width of LED register

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sys_addr  input  32  byte address; only [7:2] decoded (bus has already decoded [12:8])
sys_rd_data  output  32  registered read data, valid the cycle after a read request
sys_wr_data  input  32  write data, full-word writes only (no byte mask on this interface)
sys_en  input  1  request strobe, one cycle per access
sys_wr_en  input  1  1 = write, 0 = read; qualified by sys_en
timer_irq  output  1  machine timer interrupt, level
soft_irq  output  1  machine software interrupt, level (see Optional Feature)
uart_tx  output  1  serial line, idle high
led  output  LED_W  LED register

Behaviour:
- Interface: one clock; reset is synchronous and active-high (rst); all state is reset on a rst=1 clock edge, including mid-frame.
- Register map (byte offsets): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 UART_TX (W: bits[7:0]; R: 0), 0x14 UART_STATUS (R: bit0 shifter busy, bit1 holding full), 0x18 LED (RW, low LED_W bits), 0x1C MSIP. All other offsets read 0; writes to them are ignored.
- Read: sys_en=1 and sys_wr_en=0 at edge N loads sys_rd_data; the value reflects register state before edge N; it is visible from N+1. sys_rd_data holds its value when there is no read. It resets to 0.
- Write: sys_en=1 and sys_wr_en=1 takes effect at the same edge; sys_rd_data is unchanged.
- Prescaler: counts 0..TIME_PRESCALE-1 and emits a tick on wrap.
- mtime: 64-bit, increments by 1 on each tick and wraps 0xFFFF_FFFF_FFFF_FFFF -> 0. A carry from LO propagates to HI in the same cycle.
- A write to MTIME_LO or MTIME_HI replaces that half. It takes precedence over a tick in the same cycle; the tick is lost and the other half is untouched. No read latching: software uses the hi-lo-hi sequence.
- mtimecmp: resets to all ones. Each half is written independently.
- timer_irq is registered: timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare on current register values, so there is 1 cycle of lag after the condition becomes true. Reset 0.
- UART holding register:
  - A write to UART_TX while the holding register is empty stores the byte and sets the full flag.
  - A write while it is full is dropped silently.
- UART FSM: IDLE -> START -> DATA -> STOP -> IDLE. Each state lasts UART_DIV cycles; DATA lasts 8×UART_DIV, LSB first.
  - In IDLE with the holding register full: the shifter loads the byte, the full flag clears in the same cycle, and the FSM goes to START.
  - A holding write in the same cycle as that load is accepted (the slot frees at that edge).
  - In STOP with the holding register full: after the stop bit the FSM returns to IDLE for exactly 1 cycle, then loads.
  - uart_tx: 1 in IDLE and STOP, 0 in START, data bit in DATA. Reset 1. Busy = state != IDLE.
- led: resets to 0.

Optional Feature:
- SNOWFLAKE_SYS_MSIP_EN defined: MSIP offset 0x1C is a 1-bit RW register (bit0). soft_irq = MSIP bit, reset 0, asserts the cycle after the write edge.
- Not defined: 0x1C reads 0, writes are ignored, and soft_irq is tied to 0.

Decomposition:
- Package snowflake_sys_pkg holds the register offset constants (SYS_MTIME_LO … SYS_MSIP as 6-bit word indices), the UART state enum (UART_IDLE, UART_START, UART_DATA, UART_STOP), and the status bit positions.
- One sub-module: snowflake_uart_tx (holding register, bit counter, baud counter, FSM). Ports: clk, rst, wr, wr_data[7:0], busy, full, tx.
- The timer and register decode stay in the top level.

Test Plan:
- Reset: after rst, read 0x00/0x08/0x0C/0x14/0x18 -> 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, 0; uart_tx=1, timer_irq=0; sys_rd_data valid exactly 1 cycle after sys_en.
- Timer carry (TIME_PRESCALE=4): write MTIME_LO=0xFFFFFFFF, MTIME_HI=0 -> after 4 cycles read LO=0, HI=1. Write LO in the tick cycle -> written value wins.
- Interrupt: MTIMECMP_HI=0, MTIMECMP_LO=10, MTIME=0, prescale 1 -> timer_irq rises 1 cycle after mtime reaches 10. Write MTIMECMP_LO=0xFFFFFFFF, MTIMECMP_HI=0xFFFFFFFF -> irq drops.
- UART frame (UART_DIV=4): write 0x55 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 × 4 cycles each (LSB first), then high 4; busy=1 throughout.
- Back-pressure: during frame, write 0xA3 (held, status=0b11), then write 0x7E -> dropped. Only 0x55 and 0xA3 appear on the line, with exactly one idle cycle between frames.
- MSIP (with SNOWFLAKE_SYS_MSIP_EN): write 1 -> soft_irq=1 next cycle, reads 1. Without the macro: reads 0, soft_irq stays 0. Reset asserted mid-UART-frame -> tx=1, FSM IDLE, holding empty next cycle.
